// File: rtl/bitrev_stream_reorder.sv
// bitrev_stream_reorder
// Ping-pong reorder buffer: FFT results arrive in bit-reversed index order
// and leave in natural index order (or in arrival order when reorder_en=0).
// One bank is written while the other is read.
// Optional feature macro: BITREV_OUT_IDX_EN adds the out_idx port, which
// carries the natural index of the sample on out_data.
module bitrev_stream_reorder #(
    parameter int IDX_WIDTH  = 9,
    parameter int NUM        = 512,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  reorder_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
`ifdef BITREV_OUT_IDX_EN
    ,
    output logic [IDX_WIDTH-1:0]  out_idx
`endif
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM - 1);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    // Both banks share one array; the bank pointer is the top address bit.
    logic [DATA_WIDTH-1:0] mem_q [0:2*NUM-1];

    // Write side
    logic                 wb_q, wb_d;
    logic [IDX_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [1:0]           full_q, full_d;

    // Read side
    logic [0:0]           state_q, state_d;
    logic                 mode_q, mode_d;
    logic                 rb_q, rb_d;
    logic [IDX_WIDTH-1:0] rcnt_q, rcnt_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q;

    logic                 wr_fire;
    logic                 fetch;
    logic [IDX_WIDTH-1:0] rcnt_rev;
    logic [IDX_WIDTH-1:0] rd_addr;

    assign in_ready = !full_q[wb_q];
    assign wr_fire  = in_valid && in_ready;

    // Mirror the read counter bit by bit to get the bit-reversed address.
    generate
        for (genvar gi = 0; gi < IDX_WIDTH; gi++) begin : g_rev
            assign rcnt_rev[gi] = rcnt_q[IDX_WIDTH-1-gi];
        end
    endgenerate

    assign rd_addr = mode_q ? rcnt_rev : rcnt_q;

    // Next-state logic for write pointer, bank flags, read FSM and output flags.
    always_comb begin
        wcnt_d      = wcnt_q;
        wb_d        = wb_q;
        full_d      = full_q;
        state_d     = state_q;
        mode_d      = mode_q;
        rb_d        = rb_q;
        rcnt_d      = rcnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        fetch       = 1'b0;

        if (wr_fire) begin
            if (wcnt_q == LAST_IDX) begin
                wcnt_d       = '0;
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (full_q[rb_q]) begin
                    state_d = S_STREAM;
                    mode_d  = reorder_en;
                    rcnt_d  = '0;
                end
            end
            default: begin
                fetch = full_q[rb_q] && (!out_valid_q || out_ready);
            end
        endcase

        if (fetch) begin
            out_valid_d = 1'b1;
            out_last_d  = (rcnt_q == LAST_IDX);
            if (rcnt_q == LAST_IDX) begin
                // Read bank and write bank always differ, so this never
                // collides with the write-side flag update above.
                rcnt_d       = '0;
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
                if (full_q[!rb_q]) begin
                    mode_d = reorder_en;
                end else begin
                    state_d = S_IDLE;
                end
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Frame storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[{wb_q, wcnt_q}] <= in_data;
        end
    end

    // Registered memory read into the output data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q <= '0;
        end else if (fetch) begin
            out_data_q <= mem_q[{rb_q, rd_addr}];
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q        <= 1'b0;
            wcnt_q      <= '0;
            full_q      <= 2'b00;
            state_q     <= S_IDLE;
            mode_q      <= 1'b1;
            rb_q        <= 1'b0;
            rcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            wb_q        <= wb_d;
            wcnt_q      <= wcnt_d;
            full_q      <= full_d;
            state_q     <= state_d;
            mode_q      <= mode_d;
            rb_q        <= rb_d;
            rcnt_q      <= rcnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

`ifdef BITREV_OUT_IDX_EN
    logic [IDX_WIDTH-1:0] out_idx_q;

    // Natural index travels with the sample it labels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_idx_q <= '0;
        end else if (fetch) begin
            out_idx_q <= rcnt_q;
        end
    end

    assign out_idx = out_idx_q;
`endif

endmodule

// File: tb/tb_bitrev_stream_reorder.sv
// Testbench for bitrev_stream_reorder: a small (8-point) instance for the
// directed scenarios and a default-size instance for a random frame with
// output stalls. Checks against a frame-level model of the reorder.
module tb_bitrev_stream_reorder;

    localparam int SW = 3;
    localparam int SN = 8;
    localparam int LW = 9;
    localparam int LN = 512;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Small instance
    logic          s_in_valid, s_in_ready, s_reorder;
    logic          s_out_valid, s_out_ready, s_out_last;
    logic [DW-1:0] s_in_data, s_out_data;
    logic [SW-1:0] s_out_idx;

    // Large instance
    logic          l_in_valid, l_in_ready, l_reorder;
    logic          l_out_valid, l_out_ready, l_out_last;
    logic [DW-1:0] l_in_data, l_out_data;
    logic [LW-1:0] l_out_idx;

    bitrev_stream_reorder #(.IDX_WIDTH(SW), .NUM(SN), .DATA_WIDTH(DW)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .reorder_en(s_reorder),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_last(s_out_last)
`ifdef BITREV_OUT_IDX_EN
        , .out_idx(s_out_idx)
`endif
    );

    bitrev_stream_reorder #(.IDX_WIDTH(LW), .NUM(LN), .DATA_WIDTH(DW)) dut_l (
        .clk(clk), .rst(rst),
        .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
        .reorder_en(l_reorder),
        .out_valid(l_out_valid), .out_ready(l_out_ready),
        .out_data(l_out_data), .out_last(l_out_last)
`ifdef BITREV_OUT_IDX_EN
        , .out_idx(l_out_idx)
`endif
    );

`ifndef BITREV_OUT_IDX_EN
    assign s_out_idx = '0;
    assign l_out_idx = '0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected and observed output streams
    logic [DW-1:0] s_exp_d[$], s_got_d[$], l_got_d[$];
    logic          s_exp_l[$], s_got_l[$], l_got_l[$];
    int            s_exp_i[$], s_got_i[$], l_got_i[$];
    int            s_got_c[$];

    // Output handshakes are recorded half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (!rst && s_out_valid && s_out_ready) begin
            s_got_d.push_back(s_out_data);
            s_got_l.push_back(s_out_last);
            s_got_i.push_back(int'(s_out_idx));
            s_got_c.push_back(cyc);
        end
        if (!rst && l_out_valid && l_out_ready) begin
            l_got_d.push_back(l_out_data);
            l_got_l.push_back(l_out_last);
            l_got_i.push_back(int'(l_out_idx));
        end
    end

    // Bit reversal by repeated halving: the low bit of x becomes the high bit of r.
    function automatic int brev(input int x, input int w);
        int r = 0;
        int v = x;
        for (int j = 0; j < w; j++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic s_step();
        @(posedge clk);
        #1;
    endtask

    // Model of one small frame: the k-th arrival is X[brev(k)], so X[n] is arrival brev(n).
    task automatic s_model(input logic [DW-1:0] fr [0:SN-1], input logic reorder);
        for (int n = 0; n < SN; n++) begin
            s_exp_d.push_back(reorder ? fr[brev(n, SW)] : fr[n]);
            s_exp_l.push_back(n == SN - 1);
            s_exp_i.push_back(n);
        end
    endtask

    task automatic s_send(input logic [DW-1:0] d);
        logic acc;
        int   guard = 0;
        s_in_valid = 1'b1;
        s_in_data  = d;
        forever begin
            @(negedge clk);
            acc = s_in_ready;
            s_step();
            if (acc) break;
            guard++;
            if (guard > 200) begin
                vectors++;
                miscompares++;
                $error("FAIL s_send_timeout: observed no handshake expected in_ready within 200 cycles");
                break;
            end
        end
        s_in_valid = 1'b0;
    endtask

    task automatic s_send_frame(input logic [DW-1:0] fr [0:SN-1]);
        for (int k = 0; k < SN; k++) s_send(fr[k]);
    endtask

    task automatic s_wait(input int n);
        int guard = 0;
        while (s_got_d.size() < n && guard < 2000) begin
            s_step();
            guard++;
        end
        if (s_got_d.size() < n) begin
            vectors++;
            miscompares++;
            $error("FAIL s_wait_timeout: observed %0d outputs expected %0d", s_got_d.size(), n);
        end
    endtask

    task automatic s_compare(input string tag);
        int n = 0;
        while (s_exp_d.size() > 0) begin
            if (s_got_d.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL %s_missing: observed 0 outputs expected %0d more", tag, s_exp_d.size());
                s_exp_d.delete();
                s_exp_l.delete();
                s_exp_i.delete();
                break;
            end
            chk($sformatf("%s_data%0d", tag, n), 64'(s_got_d.pop_front()), 64'(s_exp_d.pop_front()));
            chk($sformatf("%s_last%0d", tag, n), 64'(s_got_l.pop_front()), 64'(s_exp_l.pop_front()));
`ifdef BITREV_OUT_IDX_EN
            chk($sformatf("%s_idx%0d", tag, n), 64'(s_got_i.pop_front()), 64'(s_exp_i.pop_front()));
`else
            void'(s_got_i.pop_front());
            void'(s_exp_i.pop_front());
`endif
            void'(s_got_c.pop_front());
            n++;
        end
        $display("frame group %s: %0d samples checked", tag, n);
    endtask

    logic [DW-1:0] fr0 [0:SN-1];
    logic [DW-1:0] fr1 [0:SN-1];
    logic [DW-1:0] fr2 [0:SN-1];
    logic [DW-1:0] lfr [0:LN-1];

    initial begin
        logic acc;
        int   guard;
        int   gap;

        rst = 1'b1;
        s_in_valid = 1'b0; s_in_data = '0; s_reorder = 1'b1; s_out_ready = 1'b1;
        l_in_valid = 1'b0; l_in_data = '0; l_reorder = 1'b1; l_out_ready = 1'b1;
        repeat (3) s_step();

        // Reset values
        chk("rst_in_ready", 64'(s_in_ready), 64'd1);
        chk("rst_out_valid", 64'(s_out_valid), 64'd0);
        chk("rst_out_data", 64'(s_out_data), 64'd0);
        chk("rst_out_last", 64'(s_out_last), 64'd0);
`ifdef BITREV_OUT_IDX_EN
        chk("rst_out_idx", 64'(s_out_idx), 64'd0);
`endif
        rst = 1'b0;
        s_step();

        // Ramp frame, natural-order output, with first-output latency
        for (int k = 0; k < SN; k++) fr0[k] = DW'(k);
        s_reorder = 1'b1;
        s_model(fr0, 1'b1);
        s_send_frame(fr0);
        chk("lat_e0_valid", 64'(s_out_valid), 64'd0);
        s_step();
        chk("lat_e1_valid", 64'(s_out_valid), 64'd0);
        s_step();
        chk("lat_e2_valid", 64'(s_out_valid), 64'd1);
        chk("lat_e2_data", 64'(s_out_data), 64'd0);
        s_wait(SN);
        s_compare("ramp_rev");

        // Ramp frame, arrival-order output
        s_reorder = 1'b0;
        s_model(fr0, 1'b0);
        s_send_frame(fr0);
        s_wait(SN);
        s_compare("ramp_arrival");

        // Three back-to-back random frames
        s_reorder = 1'b1;
        for (int k = 0; k < SN; k++) begin
            fr0[k] = $urandom; fr1[k] = $urandom; fr2[k] = $urandom;
        end
        s_model(fr0, 1'b1);
        s_model(fr1, 1'b1);
        s_model(fr2, 1'b1);
        s_send_frame(fr0);
        s_send_frame(fr1);
        s_send_frame(fr2);
        s_wait(3 * SN);
        gap = (s_got_c.size() > SN) ? (s_got_c[SN] - s_got_c[SN-1]) : -1;
        chk("b2b_no_bubble", 64'(gap), 64'd1);
        s_compare("b2b");

        // Backpressure: both banks fill with the output stalled
        for (int k = 0; k < SN; k++) begin
            fr0[k] = $urandom; fr1[k] = $urandom;
        end
        s_out_ready = 1'b0;
        s_model(fr0, 1'b1);
        s_model(fr1, 1'b1);
        s_send_frame(fr0);
        s_send_frame(fr1);
        chk("bp_in_ready_low", 64'(s_in_ready), 64'd0);
        chk("bp_out_valid", 64'(s_out_valid), 64'd1);
        chk("bp_head_data", 64'(s_out_data), 64'(fr0[0]));
        repeat (3) s_step();
        chk("bp_hold_valid", 64'(s_out_valid), 64'd1);
        chk("bp_hold_data", 64'(s_out_data), 64'(fr0[0]));
        chk("bp_hold_last", 64'(s_out_last), 64'd0);
        chk("bp_hold_in_ready", 64'(s_in_ready), 64'd0);
        s_out_ready = 1'b1;
        for (int i = 1; i < SN; i++) begin
            s_step();
            chk($sformatf("bp_in_ready_after_fetch%0d", i), 64'(s_in_ready),
                (i == SN - 1) ? 64'd1 : 64'd0);
        end
        s_wait(2 * SN);
        s_compare("backpressure");

        // Reset while frame 0 is half read and frame 1 partly written
        for (int k = 0; k < SN; k++) begin
            fr0[k] = $urandom; fr1[k] = $urandom;
        end
        s_send_frame(fr0);
        for (int k = 0; k < 5; k++) s_send(fr1[k]);
        rst = 1'b1;
        #1;
        chk("mrst_out_valid", 64'(s_out_valid), 64'd0);
        chk("mrst_in_ready", 64'(s_in_ready), 64'd1);
        chk("mrst_out_last", 64'(s_out_last), 64'd0);
        s_step();
        rst = 1'b0;
        s_got_d.delete(); s_got_l.delete(); s_got_i.delete(); s_got_c.delete();
        s_exp_d.delete(); s_exp_l.delete(); s_exp_i.delete();
        s_step();
        for (int k = 0; k < SN; k++) fr2[k] = $urandom;
        s_model(fr2, 1'b1);
        s_send_frame(fr2);
        s_wait(SN);
        s_compare("post_reset");
        repeat (20) s_step();
        chk("post_reset_no_extra", 64'(s_got_d.size()), 64'd0);

        // Default-size frame with random output stalls
        l_reorder = 1'b1;
        for (int k = 0; k < LN; k++) lfr[k] = $urandom;
        for (int k = 0; k < LN; k++) begin
            l_in_valid = 1'b1;
            l_in_data  = lfr[k];
            guard = 0;
            forever begin
                l_out_ready = ($urandom_range(3) != 0);
                @(negedge clk);
                acc = l_in_ready;
                s_step();
                if (acc) break;
                guard++;
                if (guard > 200) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL l_send_timeout: observed no handshake expected in_ready at sample %0d", k);
                    break;
                end
            end
        end
        l_in_valid = 1'b0;
        guard = 0;
        while (l_got_d.size() < LN && guard < 5000) begin
            l_out_ready = ($urandom_range(3) != 0);
            s_step();
            guard++;
        end
        l_out_ready = 1'b1;
        chk("large_count", 64'(l_got_d.size()), 64'(LN));
        for (int n = 0; n < LN && n < l_got_d.size(); n++) begin
            chk($sformatf("large_data%0d", n), 64'(l_got_d[n]), 64'(lfr[brev(n, LW)]));
            chk($sformatf("large_last%0d", n), 64'(l_got_l[n]), (n == LN - 1) ? 64'd1 : 64'd0);
`ifdef BITREV_OUT_IDX_EN
            chk($sformatf("large_idx%0d", n), 64'(l_got_i[n]), 64'(n));
`endif
        end
        $display("frame group large: %0d samples checked", l_got_d.size());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
